// File: rtl/laplace_pkg.sv
// Shared state type, default pixel width and counter sizing for the Laplacian window front end.
package laplace_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int PIX_W_DEF = 8;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int CNT_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// One image row of circular storage; the registered read port forwards a same-cycle write.
module laplace_line_buffer
    import laplace_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int DEPTH = 64,
    localparam int AW = CNT_W(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: the row store has no reset; every location is rewritten before it is read for a real window.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/laplace_window_gen.sv
// Streams a raster frame and emits each pixel's 4-neighbour cross using two line buffers.
// Build option: define LAPLACE_BORDER_ZERO_EN to force out-of-image neighbours to 0 instead of replicating the centre.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_b,
    output logic [PIX_W-1:0] out_d,
    output logic [PIX_W-1:0] out_e,
    output logic [PIX_W-1:0] out_f,
    output logic [PIX_W-1:0] out_h,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = CNT_W(IMG_W);
    localparam int RW = CNT_W(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t           state;
    logic [CW-1:0]    in_col, col_n, la_addr;
    logic [RW-1:0]    in_row;
    logic [PIX_W-1:0] tap_d, tap_e, lb0_q, lb1_q;
    logic [PIX_W-1:0] border, win_b, win_d, win_f, win_h;
    logic             can_load, accept, flush_step, advance;
    logic             top_edge, left_edge, right_edge;

    assign can_load = !out_valid || out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = can_load;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign flush_step = (state == FLUSH) && !(out_valid && out_last) && can_load;
    assign advance    = accept || flush_step;

    // Read ports run one column ahead so their registered data lines up with the current column.
    assign col_n   = rst ? '0 : (!advance ? in_col : ((in_col == COL_LAST) ? '0 : in_col + CW'(1)));
    assign la_addr = (col_n == COL_LAST) ? '0 : col_n + CW'(1);

    // lb0 holds row r and supplies the right neighbour; lb1 holds row r-1 for the up neighbour.
    laplace_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .wr_addr (in_col),
        .wr_data (in_pix),
        .rd_addr (la_addr),
        .rd_data (lb0_q)
    );

    laplace_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .we      (accept && (state == RUN)),
        .wr_addr (in_col),
        .wr_data (tap_e),
        .rd_addr (col_n),
        .rd_data (lb1_q)
    );

`ifdef LAPLACE_BORDER_ZERO_EN
    assign border = '0;
`else
    assign border = tap_e;
`endif

    assign top_edge   = (state == RUN) && (in_row == RW'(1));
    assign left_edge  = (in_col == '0);
    assign right_edge = (in_col == COL_LAST);

    assign win_b = top_edge   ? border : lb1_q;
    assign win_d = left_edge  ? border : tap_d;
    assign win_f = right_edge ? border : lb0_q;
    assign win_h = (state == FLUSH) ? border : in_pix;

    assign busy = (state != FILL) || (in_col != '0) || (in_row != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            in_col    <= '0;
            in_row    <= '0;
            tap_d     <= '0;
            tap_e     <= '0;
            out_b     <= '0;
            out_d     <= '0;
            out_e     <= '0;
            out_f     <= '0;
            out_h     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            in_col <= col_n;
            if (advance) begin
                tap_d <= tap_e;
                tap_e <= lb0_q;
            end
            if (accept && (in_col == COL_LAST)) begin
                in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
            end

            case (state)
                FILL: if (accept && (in_col == COL_LAST)) state <= RUN;
                RUN: if (accept && (in_col == COL_LAST) && (in_row == ROW_LAST)) state <= FLUSH;
                FLUSH: if (out_valid && out_last && out_ready) state <= FILL;
                default: state <= FILL;
            endcase

            if ((state != FILL) && advance) begin
                out_b     <= win_b;
                out_d     <= win_d;
                out_e     <= tap_e;
                out_f     <= win_f;
                out_h     <= win_h;
                out_valid <= 1'b1;
                out_last  <= (state == FLUSH) && (in_col == COL_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laplace_window_gen.sv
// Scoreboard bench for laplace_window_gen on a 4x3 image with directed and randomised flow control.
module tb_laplace_window_gen;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef struct packed {
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] d;
        logic [PIX_W-1:0] e;
        logic [PIX_W-1:0] f;
        logic [PIX_W-1:0] h;
        logic             last;
    } win_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PIX_W-1:0] in_pix = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] out_b, out_d, out_e, out_f, out_h;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             busy;

    win_t sb[$];
    win_t mon_obs, mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    int   total_popped = 0;

    laplace_window_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_b     (out_b),
        .out_d     (out_d),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_h     (out_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input int base, input int r, input int c);
        return PIX_W'(base + r * IMG_W + c);
    endfunction

    function automatic win_t golden(input int base, input int r, input int c);
        win_t             w;
        logic [PIX_W-1:0] bd;
        w.e = pix(base, r, c);
`ifdef LAPLACE_BORDER_ZERO_EN
        bd = '0;
`else
        bd = w.e;
`endif
        w.b    = (r > 0)         ? pix(base, r - 1, c) : bd;
        w.d    = (c > 0)         ? pix(base, r, c - 1) : bd;
        w.f    = (c < IMG_W - 1) ? pix(base, r, c + 1) : bd;
        w.h    = (r < IMG_H - 1) ? pix(base, r + 1, c) : bd;
        w.last = (r == IMG_H - 1) && (c == IMG_W - 1);
        return w;
    endfunction

    // Pops the scoreboard on every output handshake; the first frame also gets hand-computed windows.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_obs = {out_b, out_d, out_e, out_f, out_h, out_last};
            check("window_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                check($sformatf("win%0d", total_popped), 64'(mon_obs), 64'(mon_exp));
            end
`ifdef LAPLACE_BORDER_ZERO_EN
            if (total_popped == 0)  check("corner0", 64'(mon_obs), 64'({8'd0, 8'd0, 8'd10, 8'd11, 8'd14, 1'b0}));
            if (total_popped == 11) check("last_h", 64'({out_h, out_last}), 64'({8'd0, 1'b1}));
`else
            if (total_popped == 0)  check("corner0", 64'(mon_obs), 64'({8'd10, 8'd10, 8'd10, 8'd11, 8'd14, 1'b0}));
            if (total_popped == 11) check("last_h", 64'({out_h, out_last}), 64'({8'd21, 1'b1}));
`endif
            if (total_popped == 5)  check("interior5", 64'(mon_obs), 64'({8'd11, 8'd14, 8'd15, 8'd16, 8'd19, 1'b0}));
            popped++;
            total_popped++;
        end
    end

    task automatic drain(input int rpct);
        int guard = 0;
        while (sb.size() != 0 && guard < 4000) begin
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b1;
        check("drain_done", 64'(sb.size()), 64'(0));
        check("frame_windows", 64'(popped), 64'(NPIX));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic run_frame(input int base, input int npix, input int vpct, input int rpct,
                             input int stall_at, input bit chk_lat);
        int   idx = 0;
        int   guard = 0;
        bit   acc;
        bit   stalled = 1'b0;
        win_t snap;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                sb.push_back(golden(base, r, c));
        popped = 0;
        while (idx < npix && guard < 4000) begin
            if (stall_at >= 0 && !stalled && popped == stall_at && out_valid) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_pix    = pix(base, idx / IMG_W, idx % IMG_W);
                snap      = {out_b, out_d, out_e, out_f, out_h, out_last};
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold", 64'({out_valid, out_b, out_d, out_e, out_f, out_h, out_last}),
                          64'({1'b1, snap}));
                    check("stall_in_ready", 64'(in_ready), 64'(0));
                    @(posedge clk);
                    #1;
                end
            end
            in_valid  = ($urandom_range(99) < vpct);
            in_pix    = pix(base, idx / IMG_W, idx % IMG_W);
            out_ready = ($urandom_range(99) < rpct);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (chk_lat && idx <= 4) check("first_valid_latency", 64'(out_valid), 64'(idx == 4));
                idx++;
            end
            guard++;
        end
        in_valid = 1'b0;
        check("pixels_accepted", 64'(idx), 64'(npix));
        if (npix == NPIX) begin
            check("flush_in_ready", 64'(in_ready), 64'(0));
            drain(rpct);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_outputs", 64'({out_b, out_d, out_e, out_f, out_h}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous frame, then a back-to-back frame with a 5-cycle downstream stall on window 2.
        run_frame(10, NPIX, 100, 100, -1, 1'b1);
        run_frame(10, NPIX, 100, 100, 2, 1'b0);

        // Abort a frame after 6 pixels, then a clean frame must follow.
        run_frame(30, 6, 100, 100, -1, 1'b0);
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_out_valid", 64'(out_valid), 64'(0));
        check("mid_reset_busy", 64'(busy), 64'(0));
        sb.delete();
        rst = 1'b0;
        run_frame(10, NPIX, 100, 100, -1, 1'b0);

        // Random input bubbles and downstream backpressure.
        for (int f = 0; f < 3; f++) begin
            run_frame(40 + f * 60, NPIX, 70, 60, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
